// File: rtl/tick_gen_pkg.sv
// Shared types and helpers for the tick generator: mode/state encodings and rate-limit decode.
package tick_gen_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int LIMIT_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Terminal count for selector k: 2**(n_count-shift0-k) - 1; larger k means a faster tick.
    function automatic logic [LIMIT_W-1:0] tick_limit(input int n_count, input int shift0, input int k);
        return (LIMIT_W'(1) << (n_count - shift0 - k)) - LIMIT_W'(1);
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: IDLE/RUN FSM with a free-running counter against a selectable limit.
// Tick is registered, 1 cycle after the terminal-count cycle; no backpressure. Optional i_sync via TICK_GEN_SYNC_EN.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int N_COUNT = 32,
    parameter int N_SEL   = 2,
    parameter int SHIFT0  = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             mode_i,
    input  logic             start_i,
    input  logic [N_SEL-1:0] sel_i,
`ifdef TICK_GEN_SYNC_EN
    input  logic             sync_i,
`endif
    output logic             valid_o,
    output logic             busy_o
);

    state_e             state_q;
    logic [N_COUNT-1:0] cnt_q;
    logic               valid_q;

    logic [N_COUNT-1:0] limit;
    logic [N_COUNT-1:0] cnt_inc;
    logic               sync_hit;
    logic               retrigger;
    logic               terminal;

    assign limit     = N_COUNT'(tick_limit(N_COUNT, SHIFT0, int'(sel_i)));
    assign cnt_inc   = cnt_q + N_COUNT'(1);
    assign retrigger = (mode_i == MODE_ONESHOT) && start_i;
    // Compared against the live limit so a rate change past the current count wraps at once.
    assign terminal  = (cnt_q >= limit);

`ifdef TICK_GEN_SYNC_EN
    assign sync_hit = sync_i;
`else
    assign sync_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!enable_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if ((mode_i == MODE_PERIODIC) || start_i) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        // Sync or a one-shot restart reloads the count and swallows any tick due now.
                        if (sync_hit || retrigger) begin
                            cnt_q <= '0;
                        end else if (terminal) begin
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                            if (mode_i == MODE_ONESHOT) begin
                                state_q <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

    assign valid_o = valid_q;
    assign busy_o  = (state_q == RUN);

endmodule

// File: rtl/tick_gen.sv
// N_CH independent periodic/one-shot tick channels; ticks are registered, o_any_valid is their OR; no backpressure.
// Define TICK_GEN_SYNC_EN to add i_sync, which zeroes every running counter and suppresses that cycle's ticks.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int N_COUNT = 32,
    parameter int N_SEL   = 2,
    parameter int SHIFT0  = 10
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [N_CH-1:0]         i_enable,
    input  logic [N_CH-1:0]         i_mode,
    input  logic [N_CH-1:0]         i_start,
    input  logic [N_CH*N_SEL-1:0]   i_sel,
`ifdef TICK_GEN_SYNC_EN
    input  logic                    i_sync,
`endif
    output logic [N_CH-1:0]         o_valid,
    output logic [N_CH-1:0]         o_busy,
    output logic                    o_any_valid
);

    // The fastest selector must still leave at least a 1-bit exponent.
    if (N_COUNT - SHIFT0 - (2**N_SEL - 1) < 1) begin : g_bad_cfg
        $error("tick_gen: N_COUNT-SHIFT0-(2**N_SEL-1) must be at least 1");
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        tick_channel #(
            .N_COUNT (N_COUNT),
            .N_SEL   (N_SEL),
            .SHIFT0  (SHIFT0)
        ) u_ch (
            .clk_i    (i_clk),
            .rst_ni   (i_reset_n),
            .enable_i (i_enable[c]),
            .mode_i   (i_mode[c]),
            .start_i  (i_start[c]),
            .sel_i    (i_sel[c*N_SEL +: N_SEL]),
`ifdef TICK_GEN_SYNC_EN
            .sync_i   (i_sync),
`endif
            .valid_o  (o_valid[c]),
            .busy_o   (o_busy[c])
        );
    end

    assign o_any_valid = |o_valid;

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen (2 channels, 8-bit counters, SHIFT0=4): L = 15, 7, 3, 1 for sel 0..3.
module tb_tick_gen;

    logic       i_clk;
    logic       i_reset_n;
    logic [1:0] i_enable;
    logic [1:0] i_mode;
    logic [1:0] i_start;
    logic [3:0] i_sel;
`ifdef TICK_GEN_SYNC_EN
    logic       i_sync;
`endif
    logic [1:0] o_valid;
    logic [1:0] o_busy;
    logic       o_any_valid;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n;

    // Expected tick cycles per channel, pushed when stimulus is driven.
    int q0[$];
    int q1[$];

    tick_gen #(
        .N_CH    (2),
        .N_COUNT (8),
        .N_SEL   (2),
        .SHIFT0  (4)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_enable    (i_enable),
        .i_mode      (i_mode),
        .i_start     (i_start),
        .i_sel       (i_sel),
`ifdef TICK_GEN_SYNC_EN
        .i_sync      (i_sync),
`endif
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_any_valid (o_any_valid)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Scoreboard: every cycle each channel must tick exactly when its queue head says so.
    always @(negedge i_clk) begin : mon
        logic e0;
        logic e1;
        e0 = (q0.size() > 0) && (q0[0] == cyc);
        e1 = (q1.size() > 0) && (q1[0] == cyc);
        check_eq("valid0", 32'(o_valid[0]), 32'(e0));
        check_eq("valid1", 32'(o_valid[1]), 32'(e1));
        check_eq("any_valid", 32'(o_any_valid), 32'(e0 | e1));
        if (e0) void'(q0.pop_front());
        if (e1) void'(q1.pop_front());
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset_n = 1'b0;
        i_enable  = 2'b00;
        i_mode    = 2'b00;
        i_start   = 2'b00;
        i_sel     = 4'b0000;
`ifdef TICK_GEN_SYNC_EN
        i_sync    = 1'b0;
`endif
        #1;
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_any", 32'(o_any_valid), 32'd0);
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        check_eq("idle_busy", 32'(o_busy), 32'd0);

        // Periodic ch0, sel=2: first tick 4 cycles after RUN entry, then every 4.
        n = cyc;
        i_sel[1:0]  = 2'd2;
        i_enable[0] = 1'b1;
        q0.push_back(n + 5); q0.push_back(n + 9); q0.push_back(n + 13);
        @(negedge i_clk);
        check_eq("per_busy", 32'(o_busy[0]), 32'd1);
        repeat (12) @(negedge i_clk);
        i_enable[0] = 1'b0;
        @(negedge i_clk);
        check_eq("per_off_busy", 32'(o_busy[0]), 32'd0);

        // One-shot ch1, sel=3: single tick 2 cycles after the start edge.
        i_mode[1]   = 1'b1;
        i_sel[3:2]  = 2'd3;
        i_enable[1] = 1'b1;
        @(negedge i_clk);
        check_eq("os_idle_busy", 32'(o_busy[1]), 32'd0);
        n = cyc;
        i_start[1] = 1'b1;
        q1.push_back(n + 3);
        @(negedge i_clk);
        i_start[1] = 1'b0;
        check_eq("os_run_busy", 32'(o_busy[1]), 32'd1);
        repeat (2) @(negedge i_clk);
        check_eq("os_done_busy", 32'(o_busy[1]), 32'd0);
        repeat (4) @(negedge i_clk);

        // Retrigger ch1, sel=1: starts at t0 and t0+5 give one tick at t0+13.
        i_sel[3:2] = 2'd1;
        n = cyc;
        i_start[1] = 1'b1;
        @(negedge i_clk);
        i_start[1] = 1'b0;
        repeat (4) @(negedge i_clk);
        i_start[1] = 1'b1;
        q1.push_back(n + 14);
        @(negedge i_clk);
        i_start[1] = 1'b0;
        check_eq("rt_busy", 32'(o_busy[1]), 32'd1);
        repeat (10) @(negedge i_clk);
        check_eq("rt_done_busy", 32'(o_busy[1]), 32'd0);

        // Periodic-to-one-shot change on ch0 (sel=3): current period completes, ticks, goes IDLE.
        n = cyc;
        i_sel[1:0]  = 2'd3;
        i_mode[0]   = 1'b0;
        i_enable[0] = 1'b1;
        q0.push_back(n + 3); q0.push_back(n + 5);
        repeat (3) @(negedge i_clk);
        i_mode[0] = 1'b1;
        repeat (3) @(negedge i_clk);
        check_eq("mc_busy", 32'(o_busy[0]), 32'd0);
        i_enable[0] = 1'b0;
        i_mode[0]   = 1'b0;
        @(negedge i_clk);

        // Rate change ch0: sel 0 -> 1 at count 10 ticks next cycle, then period 8; then enable drop on terminal count.
        n = cyc;
        i_sel[1:0]  = 2'd0;
        i_enable[0] = 1'b1;
        repeat (11) @(negedge i_clk);
        i_sel[1:0] = 2'd1;
        q0.push_back(n + 12); q0.push_back(n + 20); q0.push_back(n + 28);
        repeat (24) @(negedge i_clk);
        i_enable[0] = 1'b0;
        @(negedge i_clk);
        check_eq("drop_busy", 32'(o_busy[0]), 32'd0);
        repeat (2) @(negedge i_clk);

        // Async reset mid-run, right after a tick, then restart from count 0.
        n = cyc;
        i_mode   = 2'b00;
        i_sel    = 4'b1110;
        i_enable = 2'b11;
        q0.push_back(n + 5);
        q1.push_back(n + 3); q1.push_back(n + 5);
        repeat (5) @(negedge i_clk);
        check_eq("pre_rst_busy", 32'(o_busy), 32'd3);
        #2 i_reset_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(o_valid), 32'd0);
        check_eq("arst_busy", 32'(o_busy), 32'd0);
        check_eq("arst_any", 32'(o_any_valid), 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        q0.push_back(n + 11); q0.push_back(n + 15);
        q1.push_back(n + 9); q1.push_back(n + 11); q1.push_back(n + 13); q1.push_back(n + 15);
        repeat (9) @(negedge i_clk);
        i_enable = 2'b00;
        repeat (3) @(negedge i_clk);
        check_eq("post_rst_busy", 32'(o_busy), 32'd0);

`ifdef TICK_GEN_SYNC_EN
        // Sync realigns two sel=2 channels started 2 cycles apart; ch1's due tick is suppressed.
        n = cyc;
        i_sel       = 4'b1010;
        i_enable[0] = 1'b1;
        repeat (2) @(negedge i_clk);
        i_enable[1] = 1'b1;
        q0.push_back(n + 5); q0.push_back(n + 9); q0.push_back(n + 15); q0.push_back(n + 19);
        q1.push_back(n + 7); q1.push_back(n + 15); q1.push_back(n + 19);
        repeat (8) @(negedge i_clk);
        i_sync = 1'b1;
        @(negedge i_clk);
        i_sync = 1'b0;
        repeat (8) @(negedge i_clk);
        i_enable = 2'b00;
        repeat (2) @(negedge i_clk);
        check_eq("sync_busy", 32'(o_busy), 32'd0);
`endif

        repeat (3) @(negedge i_clk);
        check_eq("q0_left", 32'(q0.size()), 32'd0);
        check_eq("q1_left", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter N_CH, default 4: number of independent tick channels.
REQ-002 Parameter N_COUNT, default 32: counter width per channel.
REQ-003 Parameter N_SEL, default 2: width of the per-channel rate selector.
REQ-004 Parameter SHIFT0, default 10: exponent offset of the slowest rate.
REQ-005 The block SHALL have these ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset; one clock, asynchronous, active-low.
- i_enable  in  N_CH  per-channel enable.
- i_mode  in  N_CH  per-channel mode: 0 periodic, 1 one-shot.
- i_start  in  N_CH  per-channel one-shot trigger pulse.
- i_sel  in  N_CH*N_SEL  packed rate selectors; channel c uses bits [c*N_SEL +: N_SEL].
- o_valid  out  N_CH  per-channel single-cycle tick.
- o_busy  out  N_CH  channel in RUN state.
- o_any_valid  out  1  OR of o_valid.

Function
REQ-006 Channel c SHALL compute limit L = 2**(N_COUNT-SHIFT0-k) - 1 from selector value k, zero-extended to N_COUNT bits.
REQ-007 Each channel SHALL be a two-state FSM with states IDLE and RUN; o_busy = (state == RUN).
REQ-008 Periodic mode: IDLE->RUN when i_enable=1; the counter increments each cycle while count < L.
REQ-009 Periodic mode: when count >= L, the counter SHALL load 0 and o_valid SHALL be 1 on the next cycle for exactly one cycle, giving period L+1.
REQ-010 One-shot mode: IDLE->RUN on i_start=1 with i_enable=1, counter loaded with 0; at count >= L, o_valid pulses once and the channel returns to IDLE.
REQ-011 One-shot retrigger: i_start=1 while in RUN SHALL reload the counter to 0 without emitting o_valid.
REQ-012 i_enable=0 SHALL force IDLE, counter 0 and o_valid 0 on the next cycle, taking priority over i_start and over a terminal count in the same cycle.
REQ-013 A change of i_sel mid-count SHALL take effect immediately; if count >= new L, the channel wraps and ticks on the next cycle.
REQ-014 A change of i_mode is sampled every cycle; a periodic-to-one-shot change in RUN completes the current period, ticks, then goes to IDLE.
REQ-015 o_valid is registered, with latency 1 cycle from the terminal-count cycle; o_any_valid is combinational from the o_valid registers.
REQ-016 Channels SHALL be fully independent, with no shared state.

Reset
REQ-017 While i_reset_n=0, all channels SHALL be IDLE with counter 0, and o_valid, o_busy and o_any_valid SHALL be 0, asynchronously.
REQ-018 Reset deassertion mid-operation SHALL restart periodic channels from count 0, with the first tick L+1 cycles after RUN entry.

Configuration
REQ-019 With macro TICK_GEN_SYNC_EN defined, the block SHALL add input i_sync (1 bit); i_sync=1 loads 0 into every RUN channel counter and suppresses that cycle's tick, for phase alignment.
REQ-020 Without TICK_GEN_SYNC_EN defined, port i_sync and its logic SHALL be absent.

Structure
REQ-021 Package tick_gen_pkg SHALL hold the mode constants (MODE_PERIODIC=0, MODE_ONESHOT=1), the state encoding (IDLE, RUN), and a limit function of (N_COUNT, SHIFT0, k).
REQ-022 Sub-module tick_channel SHALL implement one channel (FSM, counter, limit decode); tick_gen instantiates N_CH copies by generate loop.
REQ-023 An elaboration check SHALL fail if N_COUNT-SHIFT0-(2**N_SEL-1) < 1.

Verification (N_CH=2, N_COUNT=8, N_SEL=2, SHIFT0=4; L = 15, 7, 3, 1 for sel 0..3)
REQ-024 Periodic: ch0 enable=1, sel=2 -> o_valid[0] pulses every 4 cycles; first pulse 4 cycles after RUN entry.
REQ-025 One-shot: ch1 mode=1, sel=3, start pulse -> exactly one o_valid[1] pulse 2 cycles later, then o_busy[1]=0.
REQ-026 Retrigger: one-shot sel=1, start at t0 and again at t0+5 -> single tick at t0+13.
REQ-027 Rate change: periodic sel=0 at count 10, switch to sel=1 -> tick next cycle, then period 8.
REQ-028 Enable drop on the terminal-count cycle -> no tick; counter 0; o_busy=0 next cycle.
REQ-029 Assert i_reset_n=0 asynchronously mid-count -> all outputs 0 immediately; with TICK_GEN_SYNC_EN, i_sync realigns both channels so their ticks coincide.
